// File: rtl/morse_keyer.sv
// Morse keyer: one character per valid/ready handshake, keyed out with ITU dot-unit timing.
// Optional sidetone generator is enabled by defining MORSE_TONE_EN.
module morse_keyer #(
   parameter int UNIT_CYCLES = 1000,
   parameter int TONE_HALF   = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       char_valid,
   input  logic [5:0] char_code,
   output logic       char_ready,
   output logic       key_out,
   output logic       busy,
   output logic       char_done,
   output logic       tone_out
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MARK     = 3'd1,
      S_SYM_GAP  = 3'd2,
      S_CHAR_GAP = 3'd3,
      S_SPACE    = 3'd4
   } state_t;

   localparam int            CW        = $clog2(UNIT_CYCLES);
   localparam logic [CW-1:0] UNIT_LAST = CW'(UNIT_CYCLES - 1);

   if (UNIT_CYCLES < 2 || TONE_HALF < 1) begin : g_param_check
      $error("morse_keyer: UNIT_CYCLES must be >= 2 and TONE_HALF >= 1");
   end

   // {len[2:0], pat[4:0]}, pattern LSB-first, 1 = dash
   function automatic logic [7:0] lookup(input logic [5:0] code);
      logic [7:0] e;
      case (code)
         6'd0:  e = {3'd2, 5'b00010};
         6'd1:  e = {3'd4, 5'b00001};
         6'd2:  e = {3'd4, 5'b00101};
         6'd3:  e = {3'd3, 5'b00001};
         6'd4:  e = {3'd1, 5'b00000};
         6'd5:  e = {3'd4, 5'b00100};
         6'd6:  e = {3'd3, 5'b00011};
         6'd7:  e = {3'd4, 5'b00000};
         6'd8:  e = {3'd2, 5'b00000};
         6'd9:  e = {3'd4, 5'b01110};
         6'd10: e = {3'd3, 5'b00101};
         6'd11: e = {3'd4, 5'b00010};
         6'd12: e = {3'd2, 5'b00011};
         6'd13: e = {3'd2, 5'b00001};
         6'd14: e = {3'd3, 5'b00111};
         6'd15: e = {3'd4, 5'b00110};
         6'd16: e = {3'd4, 5'b01011};
         6'd17: e = {3'd3, 5'b00010};
         6'd18: e = {3'd3, 5'b00000};
         6'd19: e = {3'd1, 5'b00001};
         6'd20: e = {3'd3, 5'b00100};
         6'd21: e = {3'd4, 5'b01000};
         6'd22: e = {3'd3, 5'b00110};
         6'd23: e = {3'd4, 5'b01001};
         6'd24: e = {3'd4, 5'b01101};
         6'd25: e = {3'd4, 5'b00011};
         6'd26: e = {3'd5, 5'b11111};
         6'd27: e = {3'd5, 5'b11110};
         6'd28: e = {3'd5, 5'b11100};
         6'd29: e = {3'd5, 5'b11000};
         6'd30: e = {3'd5, 5'b10000};
         6'd31: e = {3'd5, 5'b00000};
         6'd32: e = {3'd5, 5'b00001};
         6'd33: e = {3'd5, 5'b00011};
         6'd34: e = {3'd5, 5'b00111};
         6'd35: e = {3'd5, 5'b01111};
         default: e = {3'd1, 5'b00000};
      endcase
      return e;
   endfunction

   state_t        state_q;
   logic [CW-1:0] cyc_q;
   logic [1:0]    unit_q;
   logic [4:0]    pat_q;
   logic [2:0]    idx_q;
   logic [2:0]    last_q;
   logic          key_q;
   logic          busy_q;
   logic          done_q;
   logic          ready_q;

   logic          unit_end_s;
   logic [1:0]    unit_need_s;
   logic          state_done_s;
   logic [7:0]    entry_s;
   logic [2:0]    len_s;

   // Units remaining in the current state, expressed as the index of its final unit
   always_comb begin
      unit_need_s = 2'd0;
      case (state_q)
         S_MARK:     unit_need_s = pat_q[idx_q] ? 2'd2 : 2'd0;
         S_SYM_GAP:  unit_need_s = 2'd0;
         S_CHAR_GAP: unit_need_s = 2'd2;
         S_SPACE:    unit_need_s = 2'd3;
         default:    unit_need_s = 2'd0;
      endcase
   end

   assign unit_end_s   = (cyc_q == UNIT_LAST);
   assign state_done_s = unit_end_s && (unit_q == unit_need_s);
   assign entry_s      = lookup(char_code);
   assign len_s        = (entry_s[7:5] == 3'd0) ? 3'd1 : entry_s[7:5];

   // Keyer FSM with unit timing and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         unit_q  <= 2'd0;
         pat_q   <= 5'd0;
         idx_q   <= 3'd0;
         last_q  <= 3'd0;
         key_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         if (state_q == S_IDLE || state_done_s) begin
            cyc_q  <= '0;
            unit_q <= 2'd0;
         end else if (unit_end_s) begin
            cyc_q  <= '0;
            unit_q <= unit_q + 2'd1;
         end else begin
            cyc_q <= cyc_q + CW'(1);
         end
         case (state_q)
            S_IDLE: begin
               if (char_valid && ready_q) begin
                  if (char_code < 6'd36) begin
                     state_q <= S_MARK;
                     pat_q   <= entry_s[4:0];
                     last_q  <= len_s - 3'd1;
                     idx_q   <= 3'd0;
                     key_q   <= 1'b1;
                     busy_q  <= 1'b1;
                     ready_q <= 1'b0;
                  end else if (char_code == 6'd36) begin
                     state_q <= S_SPACE;
                     busy_q  <= 1'b1;
                     ready_q <= 1'b0;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            S_MARK: begin
               if (state_done_s) begin
                  key_q   <= 1'b0;
                  state_q <= (idx_q == last_q) ? S_CHAR_GAP : S_SYM_GAP;
               end
            end
            S_SYM_GAP: begin
               if (state_done_s) begin
                  idx_q   <= idx_q + 3'd1;
                  key_q   <= 1'b1;
                  state_q <= S_MARK;
               end
            end
            S_CHAR_GAP, S_SPACE: begin
               if (state_done_s) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               key_q   <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign char_ready = ready_q;
   assign key_out    = key_q;
   assign busy       = busy_q;
   assign char_done  = done_q;

`ifdef MORSE_TONE_EN
   localparam int            TW        = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

   logic [TW-1:0] tone_cnt_q;
   logic          tone_q;
   logic          mark_end_s;

   assign mark_end_s = (state_q == S_MARK) && state_done_s;

   // Sidetone: held at zero outside marks so each mark starts in phase
   always_ff @(posedge clk) begin
      if (rst || !key_q || mark_end_s) begin
         tone_cnt_q <= '0;
         tone_q     <= 1'b0;
      end else if (tone_cnt_q == TONE_LAST) begin
         tone_cnt_q <= '0;
         tone_q     <= ~tone_q;
      end else begin
         tone_cnt_q <= tone_cnt_q + TW'(1);
      end
   end

   assign tone_out = tone_q;
`else
   assign tone_out = 1'b0;
`endif

endmodule
